dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Controller that runs one DSP slice as a multiply-accumulate engine.
- Accepts a job (start + length N), then takes N operand pairs over a valid/ready stream.
- Drives the slice's A/B operands, OPMODE, clock-enable and P-reset; waits out the slice pipeline; returns the 48-bit accumulated P with a done pulse.
- Sits between the sample-fetch logic and the DSP48A1-style slice.

Parameters:
- WIDTH, 18, operand width of in_a/in_b/dsp_a/dsp_b.
- LEN_W, 8, width of the job-length field (N max = 2^LEN_W - 1).
- PIPE_LAT, 4, cycles from operand/OPMODE issue to the corresponding P update visible on p_in; must be >= 1.

Ports:
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  job request, sampled in IDLE only.
- len  in  LEN_W  job length N, sampled with start.
- busy  out  1  high from accepted start through the done cycle.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a, in_b  in  WIDTH each  operand pair.
- dsp_a, dsp_b  out  WIDTH each  registered operands to the slice.
- dsp_opmode  out  8  registered OPMODE, aligned with dsp_a/dsp_b.
- dsp_ce  out  1  slice clock-enable, all stages.
- dsp_rstp  out  1  slice P-register reset.
- p_in  in  48  slice P output.
- result  out  48  captured accumulation.
- done  out  1  one-cycle completion pulse.
- err_zero_len  out  1  one-cycle pulse: start with len==0.

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE. busy, in_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, done, err_zero_len and result all go to 0. dsp_rstp=1 on the cycle after reset, then 0. Reset mid-job abandons the job: no done, result cleared.
- OPMODE codes (X=bits[1:0], Z=bits[3:2]; pre-adder, carry-in and post-subtract are always 0):
  - LOAD 8'h01: P = A*B.
  - ACC 8'h09: P = P + A*B.
  - HOLD 8'h08: P = P + 0.
  - CLR 8'h00: P = 0.
- IDLE:
  - Outputs: busy=0, in_ready=0, dsp_ce=0, dsp_opmode=CLR.
  - start=1 and len!=0: go to ISSUE next cycle. Load remaining counter = len, set first flag. busy=1 and dsp_rstp=1 for exactly that next cycle.
  - start=1 and len==0: err_zero_len=1 next cycle, stay in IDLE, busy stays 0.
- ISSUE:
  - Outputs: busy=1, in_ready=1, dsp_ce=1.
  - Beat accepted (in_valid & in_ready): next cycle dsp_a=in_a, dsp_b=in_b, dsp_opmode = LOAD if first flag else ACC. Clear first flag; decrement remaining.
  - No beat: next cycle dsp_a=dsp_b=0, dsp_opmode = CLR if first flag still set, else HOLD. Bubbles never disturb P.
  - Acceptance of the beat that brings remaining to 0: in_ready=0 from the next cycle; go to DRAIN with drain counter = PIPE_LAT.
- DRAIN:
  - Outputs: in_ready=0, dsp_ce=1, dsp_opmode=HOLD, operands 0.
  - Decrement drain counter each cycle. When it reaches 0: result <= p_in, done=1 for one cycle, then IDLE (busy=0 the following cycle).
- result holds its value until the next done or RST; a new start does not clear it.
- start while busy is ignored; it is not queued.
- in_valid in IDLE/DRAIN is ignored; no beat is consumed.
- Latency for N beats with no stalls: start at cycle 0 → done at cycle N + PIPE_LAT + 2.
- Width rules:
  - Product is signed WIDTH×WIDTH; the sequencer does no arithmetic on it.
  - The length counter is LEN_W bits. Maximum N = 2^LEN_W-1 runs without wrap.
  - The drain counter is sized for PIPE_LAT.

Test Plan:
- Basic MAC: len=3, pairs (2,3),(4,5),(-1,7) back-to-back, PIPE_LAT=4 slice model → opmodes 01,09,09 then 08×4. result=19, done at cycle 9 after start.
- Stalls: len=2, in_valid low 3 cycles before beat 1 and 2 cycles between beats → opmode 00 during the pre-first bubbles, 08 between beats. result unchanged vs. no-stall run; done delayed by exactly 5 cycles.
- Zero length: start with len=0 → err_zero_len one pulse, busy never rises, no dsp_ce.
- Start while busy: second start (len=5) mid-job → ignored. Only the first job's done occurs; the following start after done is accepted normally.
- Reset mid-op: assert RST after 2 of 4 beats → all outputs 0 next cycle, no done, result=0. A fresh len=1 job (6×7) then yields result=42.
- Max length: len=255, all pairs (1,1) → 255 beats accepted, in_ready drops after beat 255, result=255, single done pulse.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequencer that runs one DSP48A1-style slice as a multiply-accumulate engine:
// accepts a job, streams N operand pairs into the slice, drains the pipeline and returns P.
`timescale 1ns/1ps

module dsp_mac_sequencer #(
  parameter int WIDTH    = 18,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] dsp_a,
  output logic [WIDTH-1:0] dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rstp,
  input  logic [47:0]      p_in,
  output logic [47:0]      result,
  output logic             done,
  output logic             err_zero_len
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_ACC  = 8'h09;
  localparam logic [7:0] OP_HOLD = 8'h08;
  localparam logic [7:0] OP_CLR  = 8'h00;

  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("dsp_mac_sequencer: PIPE_LAT must be >= 1");
  end

  logic [1:0]         state;
  logic [LEN_W-1:0]   remaining;
  logic               first;
  logic [DRAIN_W-1:0] drain_cnt;

  // Operands are only taken while issuing; in_valid elsewhere is ignored.
  assign in_ready = (state == S_ISSUE);

  // NOTE: all state and outputs use non-blocking assignments so every register
  // sees the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      remaining    <= '0;
      first        <= 1'b0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_opmode   <= OP_CLR;
      dsp_ce       <= 1'b0;
      dsp_rstp     <= 1'b1;
      result       <= '0;
      done         <= 1'b0;
      err_zero_len <= 1'b0;
    end else begin
      done         <= 1'b0;
      err_zero_len <= 1'b0;
      dsp_rstp     <= 1'b0;

      case (state)
        S_IDLE: begin
          dsp_ce     <= 1'b0;
          dsp_opmode <= OP_CLR;
          dsp_a      <= '0;
          dsp_b      <= '0;
          // busy still set here means this is the done cycle; start is ignored.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            if (len != '0) begin
              state     <= S_ISSUE;
              remaining <= len;
              first     <= 1'b1;
              busy      <= 1'b1;
              dsp_rstp  <= 1'b1;
              dsp_ce    <= 1'b1;
            end else begin
              err_zero_len <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          dsp_ce <= 1'b1;
          if (in_valid) begin
            dsp_a      <= in_a;
            dsp_b      <= in_b;
            dsp_opmode <= first ? OP_LOAD : OP_ACC;
            first      <= 1'b0;
            remaining  <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_W'(PIPE_LAT);
            end
          end else begin
            // Bubbles leave P untouched: CLR before the first LOAD, HOLD after it.
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= first ? OP_CLR : OP_HOLD;
          end
        end

        S_DRAIN: begin
          dsp_a <= '0;
          dsp_b <= '0;
          if (drain_cnt == '0) begin
            result     <= p_in;
            done       <= 1'b1;
            state      <= S_IDLE;
            dsp_ce     <= 1'b0;
            dsp_opmode <= OP_CLR;
          end else begin
            drain_cnt  <= drain_cnt - DRAIN_W'(1);
            dsp_ce     <= 1'b1;
            dsp_opmode <= OP_HOLD;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer: a slice model drives p_in, a job planner
// derives per-cycle expected outputs from the job description, and one process compares.
`timescale 1ns/1ps

module tb_dsp_mac_sequencer;

  localparam int WIDTH    = 18;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;
  localparam int MAXC     = 1024;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_ACC  = 8'h09;
  localparam logic [7:0] OP_HOLD = 8'h08;
  localparam logic [7:0] OP_CLR  = 8'h00;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [WIDTH-1:0] dsp_a;
  logic [WIDTH-1:0] dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rstp;
  logic [47:0]      p_in;
  logic [47:0]      result;
  logic             done;
  logic             err_zero_len;

  dsp_mac_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rstp(dsp_rstp), .p_in(p_in), .result(result), .done(done),
    .err_zero_len(err_zero_len)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Slice model: P register updated from the issued operands, visible PIPE_LAT cycles later.
  logic [47:0] acc = '0;
  logic [47:0] p_line [PIPE_LAT];

  function automatic logic [47:0] slice_next(input logic [47:0] p, input logic ce,
                                             input logic rstp, input logic [7:0] op,
                                             input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] prod;
    logic [47:0] prod48;
    prod   = a * b;
    prod48 = {{(48-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    if (!ce)         return p;
    if (rstp)        return '0;
    case (op)
      OP_LOAD: return prod48;
      OP_ACC:  return p + prod48;
      OP_CLR:  return '0;
      default: return p;
    endcase
  endfunction

  initial for (int i = 0; i < PIPE_LAT; i++) p_line[i] = '0;

  always @(posedge CLK) begin
    acc       <= slice_next(acc, dsp_ce, dsp_rstp, dsp_opmode, dsp_a, dsp_b);
    p_line[0] <= slice_next(acc, dsp_ce, dsp_rstp, dsp_opmode, dsp_a, dsp_b);
    for (int i = 1; i < PIPE_LAT; i++) p_line[i] <= p_line[i-1];
  end

  assign p_in = p_line[PIPE_LAT-1];

  // Expected output timeline, indexed by cycle number.
  bit               exp_chk    [MAXC];
  logic             exp_busy   [MAXC];
  logic             exp_ready  [MAXC];
  logic             exp_ce     [MAXC];
  logic             exp_rstp   [MAXC];
  logic [7:0]       exp_op     [MAXC];
  logic [WIDTH-1:0] exp_a      [MAXC];
  logic [WIDTH-1:0] exp_b      [MAXC];
  logic             exp_done   [MAXC];
  logic             exp_err    [MAXC];
  logic [47:0]      exp_result [MAXC];
  logic [47:0]      model_result = '0;

  int pa[$];
  int pb[$];
  int pg[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_idle(input int c0, input logic [47:0] res, input logic rstp0);
    for (int c = c0; c < MAXC; c++) begin
      exp_chk[c]    = 1'b1;
      exp_busy[c]   = 1'b0;
      exp_ready[c]  = 1'b0;
      exp_ce[c]     = 1'b0;
      exp_rstp[c]   = (c == c0) ? rstp0 : 1'b0;
      exp_op[c]     = OP_CLR;
      exp_a[c]      = '0;
      exp_b[c]      = '0;
      exp_done[c]   = 1'b0;
      exp_err[c]    = 1'b0;
      exp_result[c] = res;
    end
  endtask

  task automatic set_out(input int c, input logic bz, input logic rdy, input logic ce,
                         input logic [7:0] op, input int a, input int b);
    exp_busy[c]  = bz;
    exp_ready[c] = rdy;
    exp_ce[c]    = ce;
    exp_op[c]    = op;
    exp_a[c]     = WIDTH'(a);
    exp_b[c]     = WIDTH'(b);
  endtask

  // Job planner: start seen in cycle s, beat k preceded by pg[k] bubble cycles.
  task automatic plan_job(input int s, input int n);
    int     cur;
    int     d;
    longint sum;
    fill_idle(s + 1, model_result, 1'b0);
    set_out(s + 1, 1, 1, 1, OP_CLR, 0, 0);
    exp_rstp[s + 1] = 1'b1;
    cur = s + 1;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < pg[k]; g++) begin
        set_out(cur + 1, 1, 1, 1, (k == 0) ? OP_CLR : OP_HOLD, 0, 0);
        cur++;
      end
      sum += longint'(pa[k]) * longint'(pb[k]);
      set_out(cur + 1, 1, (k < n - 1), 1, (k == 0) ? OP_LOAD : OP_ACC, pa[k], pb[k]);
      cur++;
    end
    for (int i = 1; i <= PIPE_LAT; i++) set_out(cur + i, 1, 0, 1, OP_HOLD, 0, 0);
    d = cur + PIPE_LAT + 1;
    set_out(d, 1, 0, 0, OP_CLR, 0, 0);
    exp_done[d]  = 1'b1;
    model_result = 48'(sum);
    for (int c = d; c < MAXC; c++) exp_result[c] = model_result;
  endtask

  task automatic run_job(input int n, input bit inject, output int lat);
    int s;
    s     = cyc;
    start = 1'b1;
    len   = LEN_W'(n);
    plan_job(s, n);
    tick;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      repeat (pg[k]) tick;
      in_valid = 1'b1;
      in_a     = WIDTH'(pa[k]);
      in_b     = WIDTH'(pb[k]);
      if (inject && k == 0) begin
        start = 1'b1;
        len   = LEN_W'(5);
      end
      tick;
      start = 1'b0;
    end
    in_valid = 1'b0;
    for (int i = 0; i < PIPE_LAT + 4; i++) begin
      if (done) break;
      tick;
    end
    check("done_seen", done, 1);
    lat = cyc - s;
    if (inject) begin
      start = 1'b1;
      len   = LEN_W'(5);
      tick;
      start = 1'b0;
    end
  endtask

  // NOTE: outputs are compared on the falling edge, half a cycle away from updates.
  always @(negedge CLK) begin
    if (cyc < MAXC && exp_chk[cyc]) begin
      check("busy",         busy,         exp_busy[cyc]);
      check("in_ready",     in_ready,     exp_ready[cyc]);
      check("dsp_ce",       dsp_ce,       exp_ce[cyc]);
      check("dsp_rstp",     dsp_rstp,     exp_rstp[cyc]);
      check("dsp_opmode",   dsp_opmode,   exp_op[cyc]);
      check("dsp_a",        dsp_a,        exp_a[cyc]);
      check("dsp_b",        dsp_b,        exp_b[cyc]);
      check("done",         done,         exp_done[cyc]);
      check("err_zero_len", err_zero_len, exp_err[cyc]);
      check("result",       result,       exp_result[cyc]);
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int s;

    RST = 1'b1;
    repeat (3) tick;
    RST = 1'b0;
    fill_idle(cyc, '0, 1'b1);
    check("reset_busy",   busy,     0);
    check("reset_rstp",   dsp_rstp, 1);
    check("reset_result", result,   0);
    tick;

    // Basic MAC: 2*3 + 4*5 + (-1)*7 = 19, done 9 cycles after start.
    pa = '{2, 4, -1};  pb = '{3, 5, 7};  pg = '{0, 0, 0};
    run_job(3, 1'b0, lat);
    check("basic_result",  result,  48'd19);
    check("basic_latency", 48'(lat), 48'd9);
    repeat (2) tick;

    // Two beats, no stalls then with stalls: same result, 5 cycles later.
    pa = '{2, 4};  pb = '{3, 5};  pg = '{0, 0};
    run_job(2, 1'b0, lat);
    check("nostall_result",  result,   48'd26);
    check("nostall_latency", 48'(lat), 48'd8);
    repeat (2) tick;
    pg = '{3, 2};
    run_job(2, 1'b0, lat);
    check("stall_result",  result,   48'd26);
    check("stall_latency", 48'(lat), 48'd13);
    repeat (2) tick;

    // Zero-length job.
    s     = cyc;
    start = 1'b1;
    len   = '0;
    exp_err[s + 1] = 1'b1;
    tick;
    start = 1'b0;
    check("zero_err",  err_zero_len, 1);
    check("zero_busy", busy,         0);
    repeat (2) tick;

    // Start while busy (mid-issue and on the done cycle) is ignored; 10*-3 + 1*1 = -29.
    pa = '{10, 1};  pb = '{-3, 1};  pg = '{0, 0};
    run_job(2, 1'b1, lat);
    check("busy_result",  result,   48'hFFFF_FFFF_FFE3);
    check("busy_latency", 48'(lat), 48'd8);
    tick;
    pa = '{5};  pb = '{5};  pg = '{0};
    run_job(1, 1'b0, lat);
    check("follow_result",  result,   48'd25);
    check("follow_latency", 48'(lat), 48'd7);
    repeat (2) tick;

    // Reset after two of four beats.
    pa = '{1, 2, 3, 4};  pb = '{1, 1, 1, 1};  pg = '{0, 0, 0, 0};
    s     = cyc;
    start = 1'b1;
    len   = LEN_W'(4);
    plan_job(s, 4);
    tick;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_a     = WIDTH'(pa[k]);
      in_b     = WIDTH'(pb[k]);
      tick;
    end
    in_valid = 1'b0;
    RST      = 1'b1;
    tick;
    RST          = 1'b0;
    model_result = '0;
    fill_idle(cyc, '0, 1'b1);
    check("midrst_result", result,   0);
    check("midrst_done",   done,     0);
    check("midrst_ready",  in_ready, 0);
    repeat (2) tick;
    pa = '{6};  pb = '{7};  pg = '{0};
    run_job(1, 1'b0, lat);
    check("fresh_result", result, 48'd42);
    repeat (2) tick;

    // Maximum length: 255 beats of (1,1).
    pa.delete();  pb.delete();  pg.delete();
    for (int k = 0; k < 255; k++) begin
      pa.push_back(1);
      pb.push_back(1);
      pg.push_back(0);
    end
    run_job(255, 1'b0, lat);
    check("max_result",  result,   48'd255);
    check("max_latency", 48'(lat), 48'd261);
    repeat (3) tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
